// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle main control unit: state encoding,
// opcodes, ALUOp codes and datapath mux select encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTEXEC,
        S_RTWB,
        S_BEQ,
        S_BLEZ,
        S_LINK,
        S_ERR
    } state_t;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BLEZAL = 6'h14;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_BLEZ  = 3'b011;
    localparam logic [2:0] ALUOP_RTYPE = 3'b100;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
    localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
    localparam logic [1:0] MEMTOREG_PC     = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    // States from which a transition back to FETCH retires an instruction.
    function automatic logic is_retire_state(state_t s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RTWB) ||
               (s == S_BEQ)   || (s == S_BLEZ)  || (s == S_LINK);
    endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control: sequences fetch/decode/execute/memory/writeback,
// drives datapath controls, counts retired instructions, flags illegal opcodes.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    input  logic             cond,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       aluop,
    output logic             reg_write,
    output logic [1:0]       regdst,
    output logic [1:0]       memtoreg,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t state, next_state;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTEXEC;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_BLEZAL:    next_state = S_BLEZ;
                    default:      next_state = S_ERR;
                endcase
            end
            S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  if (mem_ready) next_state = S_FETCH;
            S_RTEXEC: next_state = S_RTWB;
            S_RTWB:   next_state = S_FETCH;
            S_BEQ:    next_state = S_FETCH;
            S_BLEZ:   next_state = cond ? S_LINK : S_FETCH;
            S_LINK:   next_state = S_FETCH;
            S_ERR:    next_state = S_ERR;
            default:  next_state = S_FETCH;
        endcase
    end

    // Controls are held at 0 during reset so an aborted instruction cannot
    // leave a partial register or PC write behind.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        alusrca       = 1'b0;
        alusrcb       = SRCB_RT;
        aluop         = ALUOP_ADD;
        reg_write     = 1'b0;
        regdst        = REGDST_RT;
        memtoreg      = MEMTOREG_ALUOUT;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    alusrcb  = SRCB_FOUR;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE: alusrcb = SRCB_IMM_SH;
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write = 1'b1;
                    memtoreg  = MEMTOREG_MDR;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_RTEXEC: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_RTYPE;
                end
                S_RTWB: begin
                    reg_write = 1'b1;
                    regdst    = REGDST_RD;
                end
                S_BEQ: begin
                    alusrca       = 1'b1;
                    aluop         = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                end
                S_BLEZ: begin
                    alusrca   = 1'b1;
                    aluop     = ALUOP_BLEZ;
                    pc_write  = cond;
                    pc_source = cond ? PCSRC_ALUOUT : PCSRC_ALU;
                end
                S_LINK: begin
                    reg_write = 1'b1;
                    regdst    = REGDST_RA;
                    memtoreg  = MEMTOREG_PC;
                end
                default: ;
            endcase
        end
    end

    // Sticky flag rises on the edge into ERR, so it is visible in ERR's first cycle.
    always_ff @(posedge clk) begin
        if (reset)                    illegal <= 1'b0;
        else if (next_state == S_ERR) illegal <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            instr_count <= '0;
        else if (is_retire_state(state) && next_state == S_FETCH)
            instr_count <= instr_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized scoreboard bench for mc_control_fsm: an instruction-level model
// queues the expected control word for every cycle; a monitor compares them.
module tb_mc_control_fsm;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluop;
        logic       reg_write;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
    } ctl_t;

    typedef struct {
        ctl_t        ctl;
        logic        ill;
        logic [31:0] cnt;
        bit          chk_status;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'h00;
    logic        mem_ready = 1'b1;
    logic        cond = 1'b0;
    logic        mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_source, alusrcb, regdst, memtoreg;
    logic        alusrca, reg_write, illegal;
    logic [2:0]  aluop;
    logic [31:0] instr_count;

    int checks = 0;
    int failures = 0;

    exp_t        sb[$];
    logic        exp_ill = 1'b0;
    logic [31:0] exp_cnt = '0;

    always #5 clk = ~clk;

    mc_control_fsm #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .cond(cond),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .reg_write(reg_write),
        .regdst(regdst), .memtoreg(memtoreg), .illegal(illegal), .instr_count(instr_count)
    );

    // Control word each step of an instruction must show, straight from the step table.
    function automatic ctl_t ctl(input string step, input logic flag);
        ctl_t c = '0;
        case (step)
            "fetch":  begin c.mem_read = 1; c.alusrcb = 2'b01; c.ir_write = flag; c.pc_write = flag; end
            "decode": c.alusrcb = 2'b11;
            "memadr": begin c.alusrca = 1; c.alusrcb = 2'b10; end
            "memrd":  begin c.mem_read = 1; c.iord = 1; end
            "memwb":  begin c.reg_write = 1; c.memtoreg = 2'b01; end
            "memwr":  begin c.mem_write = 1; c.iord = 1; end
            "rtexec": begin c.alusrca = 1; c.aluop = 3'b100; end
            "rtwb":   begin c.reg_write = 1; c.regdst = 2'b01; end
            "beq":    begin c.alusrca = 1; c.aluop = 3'b001; c.pc_write_cond = 1; c.pc_source = 2'b01; end
            "blez":   begin c.alusrca = 1; c.aluop = 3'b011; c.pc_write = flag; c.pc_source = flag ? 2'b01 : 2'b00; end
            "link":   begin c.reg_write = 1; c.regdst = 2'b10; c.memtoreg = 2'b10; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input logic rdy, input logic cnd, input ctl_t c, input string nm);
        exp_t e;
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = rdy; cond = cnd;
        e.ctl = c; e.ill = exp_ill; e.cnt = exp_cnt; e.chk_status = 1'b1; e.name = nm;
        sb.push_back(e);
    endtask

    // One reset cycle: all controls 0; status registers clear at the closing edge.
    task automatic rst_cycle();
        exp_t e;
        @(posedge clk); #1;
        reset = 1'b1; mem_ready = rnd_bit(); cond = rnd_bit();
        e.ctl = '0; e.ill = 1'b0; e.cnt = '0; e.chk_status = 1'b0; e.name = "reset";
        sb.push_back(e);
        exp_ill = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic mem_wait(input string nm, input int stalls);
        repeat (stalls) step(1'b0, rnd_bit(), ctl(nm, 1'b0), nm);
        step(1'b1, rnd_bit(), ctl(nm, 1'b1), nm);
    endtask

    // abort: 0 none, 1 reset after DECODE, 2 reset after MEMADR (LW/SW only).
    task automatic do_instr(input logic [5:0] op, input logic cnd, input int sf,
                            input int sm, input int abort);
        opcode = op;
        mem_wait("fetch", sf);
        step(rnd_bit(), rnd_bit(), ctl("decode", 1'b0), "decode");
        if (abort == 1) begin rst_cycle(); return; end
        case (op)
            6'h23: begin
                step(rnd_bit(), rnd_bit(), ctl("memadr", 1'b0), "memadr");
                if (abort == 2) begin rst_cycle(); return; end
                mem_wait("memrd", sm);
                step(rnd_bit(), rnd_bit(), ctl("memwb", 1'b0), "memwb");
                exp_cnt++;
            end
            6'h2B: begin
                step(rnd_bit(), rnd_bit(), ctl("memadr", 1'b0), "memadr");
                if (abort == 2) begin rst_cycle(); return; end
                mem_wait("memwr", sm);
                exp_cnt++;
            end
            6'h00: begin
                step(rnd_bit(), rnd_bit(), ctl("rtexec", 1'b0), "rtexec");
                step(rnd_bit(), rnd_bit(), ctl("rtwb", 1'b0), "rtwb");
                exp_cnt++;
            end
            6'h04: begin
                step(rnd_bit(), cnd, ctl("beq", 1'b0), "beq");
                exp_cnt++;
            end
            6'h14: begin
                step(rnd_bit(), cnd, ctl("blez", cnd), "blez");
                if (cnd) step(rnd_bit(), rnd_bit(), ctl("link", 1'b0), "link");
                exp_cnt++;
            end
            default: begin
                exp_ill = 1'b1;
                repeat (10) step(rnd_bit(), rnd_bit(), '0, "err");
                rst_cycle();
            end
        endcase
    endtask

    function automatic logic [5:0] rand_illegal_op();
        logic [5:0] op;
        do op = 6'($urandom_range(0, 63));
        while (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h14);
        return op;
    endfunction

    function automatic int rand_stalls();
        return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            ctl_t act;
            e = sb.pop_front();
            act = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source,
                   alusrca, alusrcb, aluop, reg_write, regdst, memtoreg};
            checks++;
            if (act !== e.ctl ||
                (e.chk_status && (illegal !== e.ill || instr_count !== e.cnt))) begin
                failures++;
                $display("FAIL %s @%0t: got ctl=%h illegal=%b count=%0d, expected ctl=%h illegal=%b count=%0d",
                         e.name, $time, act, illegal, instr_count, e.ctl, e.ill, e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst_cycle();
        rst_cycle();

        // Directed sequence following the intended bring-up scenarios.
        do_instr(6'h23, 1'b0, 0, 0, 0);
        do_instr(6'h2B, 1'b0, 0, 3, 0);
        do_instr(6'h00, 1'b0, 0, 0, 0);
        do_instr(6'h04, 1'b1, 0, 0, 0);
        do_instr(6'h14, 1'b1, 2, 0, 0);
        do_instr(6'h14, 1'b0, 0, 0, 0);
        do_instr(6'h23, 1'b0, 1, 0, 2);
        do_instr(6'h3F, 1'b0, 0, 0, 0);
        do_instr(6'h00, 1'b0, 0, 0, 0);

        for (int i = 0; i < 250; i++) begin
            r = int'($urandom_range(0, 20));
            if      (r <= 3)  do_instr(6'h23, rnd_bit(), rand_stalls(), rand_stalls(), 0);
            else if (r <= 7)  do_instr(6'h2B, rnd_bit(), rand_stalls(), rand_stalls(), 0);
            else if (r <= 10) do_instr(6'h00, rnd_bit(), rand_stalls(), 0, 0);
            else if (r <= 13) do_instr(6'h04, rnd_bit(), rand_stalls(), 0, 0);
            else if (r <= 17) do_instr(6'h14, rnd_bit(), rand_stalls(), 0, 0);
            else if (r == 18) do_instr(rand_illegal_op(), rnd_bit(), rand_stalls(), 0, 0);
            else if (r == 19) do_instr(6'h2B, rnd_bit(), rand_stalls(), 0, 2);
            else              do_instr(6'h00, rnd_bit(), rand_stalls(), 0, 1);
        end

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
